// File: rtl/chacha20_poly1305_pkg.sv
// rtl/chacha20_poly1305_pkg.sv - shared types and constants for the ChaCha20-Poly1305 sequencing controller
//   state_t          : controller state encoding
//   P_SEL_*          : poly block source codes driven on p_sel
//   *_BLOCK_BYTES    : AAD (poly) and message (chacha) block sizes
//   last_chunk()     : index of the final 16-byte chunk of a message block
//   chunk_blen()     : valid bytes of a given chunk within a message block
package chacha20_poly1305_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_KEYGEN = 4'd1,
      ST_PKEY   = 4'd2,
      ST_READY  = 4'd3,
      ST_AAD    = 4'd4,
      ST_MSG_CC = 4'd5,
      ST_MSG_P  = 4'd6,
      ST_LEN    = 4'd7,
      ST_FIN    = 4'd8,
      ST_DONE   = 4'd9
   } state_t;

   localparam logic [1:0] P_SEL_AAD = 2'd0;
   localparam logic [1:0] P_SEL_CT  = 2'd1;
   localparam logic [1:0] P_SEL_LEN = 2'd2;

   localparam logic [6:0] AAD_BLOCK_BYTES = 7'd16;
   localparam logic [6:0] MSG_BLOCK_BYTES = 7'd64;

   // b is 1..64, so (b-1)/16 lands in 0..3
   function automatic logic [1:0] last_chunk(input logic [6:0] b);
      return 2'((b - 7'd1) >> 4);
   endfunction

   // Every chunk but the last is a full 16 bytes; the last carries the remainder (1..16)
   function automatic logic [4:0] chunk_blen(input logic [6:0] b, input logic [1:0] k);
      return (k == last_chunk(b)) ? 5'(b - {1'b0, k, 4'b0000}) : 5'd16;
   endfunction

endpackage

// File: rtl/chacha20_poly1305_ctrl_if.sv
// rtl/chacha20_poly1305_ctrl_if.sv - controller-to-core bus for the chacha block core and the poly1305 core
//   master (controller): drives cc_init/cc_next, p_init/p_next/p_finish, p_sel/p_chunk/p_blen
//   slave  (cores)     : drives cc_ready, p_ready, p_tag
interface chacha20_poly1305_ctrl_if;

   logic         cc_init;
   logic         cc_next;
   logic         cc_ready;
   logic         p_init;
   logic         p_next;
   logic         p_finish;
   logic         p_ready;
   logic [127:0] p_tag;
   logic [1:0]   p_sel;
   logic [1:0]   p_chunk;
   logic [4:0]   p_blen;

   modport master (
      output cc_init, cc_next, p_init, p_next, p_finish, p_sel, p_chunk, p_blen,
      input  cc_ready, p_ready, p_tag
   );

   modport slave (
      input  cc_init, cc_next, p_init, p_next, p_finish, p_sel, p_chunk, p_blen,
      output cc_ready, p_ready, p_tag
   );

endinterface

// File: rtl/chacha20_poly1305_len_ctr.sv
// rtl/chacha20_poly1305_len_ctr.sv - AAD/message byte accumulators, partial-block flags and command legality
//   clk, reset_n        : clock, synchronous active-low reset
//   clr                 : start of a new operation, clears counters and flags
//   in_ready_state      : controller sits in READY (the only state taking data commands)
//   aad_cmd/msg_cmd/fin_cmd : priority-decoded commands presented while ready=1
//   blen                : byte count of the presented block
//   acc_aad/acc_msg/acc_fin : command accepted this cycle
//   illegal             : a command was presented but rejected
//   aad_len/msg_len     : accumulated byte counts, wrapping modulo 2^LEN_W
module chacha20_poly1305_len_ctr
   import chacha20_poly1305_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             in_ready_state,
   input  logic             aad_cmd,
   input  logic             msg_cmd,
   input  logic             fin_cmd,
   input  logic [6:0]       blen,
   output logic             acc_aad,
   output logic             acc_msg,
   output logic             acc_fin,
   output logic             illegal,
   output logic [LEN_W-1:0] aad_len,
   output logic [LEN_W-1:0] msg_len
);

   logic aad_partial;
   logic msg_seen;
   logic msg_partial;
   logic aad_blen_ok;
   logic msg_blen_ok;

   always_comb begin
      aad_blen_ok = (blen != 7'd0) && (blen <= AAD_BLOCK_BYTES);
      msg_blen_ok = (blen != 7'd0) && (blen <= MSG_BLOCK_BYTES);
      // AAD must precede all message data and only the last AAD block may be short
      acc_aad = aad_cmd & in_ready_state & ~msg_seen & ~aad_partial & aad_blen_ok;
      acc_msg = msg_cmd & in_ready_state & ~msg_partial & msg_blen_ok;
      acc_fin = fin_cmd & in_ready_state;
      illegal = (aad_cmd | msg_cmd | fin_cmd) & ~(acc_aad | acc_msg | acc_fin);
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         aad_len     <= '0;
         msg_len     <= '0;
         aad_partial <= 1'b0;
         msg_seen    <= 1'b0;
         msg_partial <= 1'b0;
      end else if (acc_aad) begin
         aad_len     <= aad_len + LEN_W'(blen);
         aad_partial <= (blen < AAD_BLOCK_BYTES);
      end else if (acc_msg) begin
         msg_len     <= msg_len + LEN_W'(blen);
         msg_seen    <= 1'b1;
         msg_partial <= (blen < MSG_BLOCK_BYTES);
      end
   end

endmodule

// File: rtl/chacha20_poly1305_ctrl.sv
// rtl/chacha20_poly1305_ctrl.sv - sequencing controller for the ChaCha20-Poly1305 AEAD core
//   clk, reset_n      : clock, synchronous active-low reset
//   init, encdec      : start a new operation (1 = encrypt), accepted in any state
//   aad_next/msg_next : absorb an AAD block (1..16 B) / process a message block (1..64 B), blen bytes
//   finalize, tag_in  : compute the tag; tag_in is the expected tag on decrypt
//   ready             : a command can be accepted
//   tag_valid/tag_correct : final tag available / matches tag_in (decrypt only)
//   core              : bus to the chacha and poly1305 cores (master side)
//   aad_len/msg_len   : accumulated byte counts
//   error             : sticky illegal-command flag, present only with CHACHA_POLY_CTRL_ERR_EN
module chacha20_poly1305_ctrl
   import chacha20_poly1305_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             init,
   input  logic             encdec,
   input  logic             aad_next,
   input  logic             msg_next,
   input  logic [6:0]       blen,
   input  logic             finalize,
   input  logic [127:0]     tag_in,
   output logic             ready,
   output logic             tag_valid,
   output logic             tag_correct,
   chacha20_poly1305_ctrl_if.master core,
   output logic [LEN_W-1:0] aad_len,
   output logic [LEN_W-1:0] msg_len
`ifdef CHACHA_POLY_CTRL_ERR_EN
   ,
   output logic             error
`endif
);

   state_t     state;
   // phase 0: state entry, 1: pulse visible, 2: ready ignored, 3: wait for core ready
   logic [1:0] phase;
   logic [1:0] chunk;
   logic [6:0] blen_q;
   logic       encdec_q;

   logic aad_cmd, msg_cmd, fin_cmd;
   logic acc_aad, acc_msg, acc_fin, illegal;
   logic core_rdy;

   always_comb begin
      fin_cmd = ready & ~init & finalize;
      msg_cmd = ready & ~init & ~finalize & msg_next;
      aad_cmd = ready & ~init & ~finalize & ~msg_next & aad_next;
   end

   assign core_rdy = (state == ST_KEYGEN || state == ST_MSG_CC) ? core.cc_ready : core.p_ready;

   chacha20_poly1305_len_ctr #(
      .LEN_W (LEN_W)
   ) u_len_ctr (
      .clk            (clk),
      .reset_n        (reset_n),
      .clr            (init),
      .in_ready_state (state == ST_READY),
      .aad_cmd        (aad_cmd),
      .msg_cmd        (msg_cmd),
      .fin_cmd        (fin_cmd),
      .blen           (blen),
      .acc_aad        (acc_aad),
      .acc_msg        (acc_msg),
      .acc_fin        (acc_fin),
      .illegal        (illegal),
      .aad_len        (aad_len),
      .msg_len        (msg_len)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         phase         <= 2'd0;
         chunk         <= 2'd0;
         blen_q        <= 7'd0;
         encdec_q      <= 1'b0;
         ready         <= 1'b1;
         tag_valid     <= 1'b0;
         tag_correct   <= 1'b0;
         core.cc_init  <= 1'b0;
         core.cc_next  <= 1'b0;
         core.p_init   <= 1'b0;
         core.p_next   <= 1'b0;
         core.p_finish <= 1'b0;
         core.p_sel    <= 2'd0;
         core.p_chunk  <= 2'd0;
         core.p_blen   <= 5'd0;
      end else begin
         core.cc_init  <= 1'b0;
         core.cc_next  <= 1'b0;
         core.p_init   <= 1'b0;
         core.p_next   <= 1'b0;
         core.p_finish <= 1'b0;
         if (init) begin
            state       <= ST_KEYGEN;
            phase       <= 2'd0;
            chunk       <= 2'd0;
            encdec_q    <= encdec;
            ready       <= 1'b0;
            tag_valid   <= 1'b0;
            tag_correct <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
               end
               ST_READY: begin
                  phase  <= 2'd0;
                  blen_q <= blen;
                  if (acc_fin) begin
                     state <= ST_LEN;
                     ready <= 1'b0;
                  end else if (acc_msg) begin
                     state <= ST_MSG_CC;
                     ready <= 1'b0;
                  end else if (acc_aad) begin
                     state <= ST_AAD;
                     ready <= 1'b0;
                  end
               end
               default: begin
                  case (phase)
                     2'd0: begin
                        phase <= 2'd1;
                        case (state)
                           ST_KEYGEN: core.cc_init <= 1'b1;
                           ST_MSG_CC: core.cc_next <= 1'b1;
                           ST_PKEY:   core.p_init  <= 1'b1;
                           ST_AAD: begin
                              core.p_next  <= 1'b1;
                              core.p_sel   <= P_SEL_AAD;
                              core.p_chunk <= 2'd0;
                              core.p_blen  <= blen_q[4:0];
                           end
                           ST_MSG_P: begin
                              core.p_next  <= 1'b1;
                              core.p_sel   <= P_SEL_CT;
                              core.p_chunk <= chunk;
                              core.p_blen  <= chunk_blen(blen_q, chunk);
                           end
                           ST_LEN: begin
                              core.p_next  <= 1'b1;
                              core.p_sel   <= P_SEL_LEN;
                              core.p_chunk <= 2'd0;
                              core.p_blen  <= 5'd16;
                           end
                           ST_FIN:  core.p_finish <= 1'b1;
                           default: begin
                           end
                        endcase
                     end
                     2'd1: phase <= 2'd2;
                     2'd2: phase <= 2'd3;
                     default: begin
                        if (core_rdy) begin
                           phase <= 2'd0;
                           case (state)
                              ST_KEYGEN: state <= ST_PKEY;
                              ST_PKEY, ST_AAD: begin
                                 state <= ST_READY;
                                 ready <= 1'b1;
                              end
                              ST_MSG_CC: begin
                                 state <= ST_MSG_P;
                                 chunk <= 2'd0;
                              end
                              ST_MSG_P: begin
                                 if (chunk == last_chunk(blen_q)) begin
                                    state <= ST_READY;
                                    ready <= 1'b1;
                                 end else begin
                                    chunk <= chunk + 2'd1;
                                 end
                              end
                              ST_LEN: state <= ST_FIN;
                              ST_FIN: begin
                                 state       <= ST_DONE;
                                 ready       <= 1'b1;
                                 tag_valid   <= 1'b1;
                                 tag_correct <= ~encdec_q & (core.p_tag == tag_in);
                              end
                              default: begin
                                 state <= ST_IDLE;
                                 ready <= 1'b1;
                              end
                           endcase
                        end
                     end
                  endcase
               end
            endcase
         end
      end
   end

`ifdef CHACHA_POLY_CTRL_ERR_EN
   always_ff @(posedge clk) begin
      if (!reset_n || init) begin
         error <= 1'b0;
      end else if (illegal) begin
         error <= 1'b1;
      end
   end
`else
   logic unused_illegal;
   assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_chacha20_poly1305_ctrl.sv
// tb/tb_chacha20_poly1305_ctrl.sv - self-checking bench for chacha20_poly1305_ctrl (honours CHACHA_POLY_CTRL_ERR_EN)
module tb_chacha20_poly1305_ctrl;

   localparam int LEN_W = 64;
   localparam logic [127:0] RFC_TAG = 128'h1ae10b594f09e26a7e902ecbd0600691;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             init = 1'b0;
   logic             encdec = 1'b0;
   logic             aad_next = 1'b0;
   logic             msg_next = 1'b0;
   logic             finalize = 1'b0;
   logic [6:0]       blen = 7'd0;
   logic [127:0]     tag_in = '0;
   logic             ready;
   logic             tag_valid;
   logic             tag_correct;
   logic [LEN_W-1:0] aad_len;
   logic [LEN_W-1:0] msg_len;
`ifdef CHACHA_POLY_CTRL_ERR_EN
   logic             error;
`endif

   chacha20_poly1305_ctrl_if cif();

   int total = 0;
   int bad = 0;

   chacha20_poly1305_ctrl #(.LEN_W(LEN_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .init        (init),
      .encdec      (encdec),
      .aad_next    (aad_next),
      .msg_next    (msg_next),
      .blen        (blen),
      .finalize    (finalize),
      .tag_in      (tag_in),
      .ready       (ready),
      .tag_valid   (tag_valid),
      .tag_correct (tag_correct),
      .core        (cif),
      .aad_len     (aad_len),
      .msg_len     (msg_len)
`ifdef CHACHA_POLY_CTRL_ERR_EN
      ,
      .error       (error)
`endif
   );

   always #5 clk = ~clk;

   // chacha core: ready drops after each request for a random number of cycles
   initial begin
      cif.cc_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (cif.cc_init || cif.cc_next) begin
            cif.cc_ready = 1'b0;
            repeat ($urandom_range(4, 0)) @(posedge clk);
            #1 cif.cc_ready = 1'b1;
         end
      end
   end

   // poly core: same behaviour on its own ready
   initial begin
      cif.p_ready = 1'b1;
      cif.p_tag   = '0;
      forever begin
         @(posedge clk);
         #1;
         if (cif.p_init || cif.p_next || cif.p_finish) begin
            cif.p_ready = 1'b0;
            repeat ($urandom_range(4, 0)) @(posedge clk);
            #1 cif.p_ready = 1'b1;
         end
      end
   end

   // observed core traffic; each p_next recorded as sel*1000 + chunk*100 + blen
   int n_cc_init = 0, n_cc_next = 0, n_p_init = 0, n_p_fin = 0;
   int obs_q[$];

   always @(negedge clk) begin
      if (reset_n) begin
         if (cif.cc_init)  n_cc_init++;
         if (cif.cc_next)  n_cc_next++;
         if (cif.p_init)   n_p_init++;
         if (cif.p_finish) n_p_fin++;
         if (cif.p_next)
            obs_q.push_back(int'(cif.p_sel) * 1000 + int'(cif.p_chunk) * 100 + int'(cif.p_blen));
      end
   end

   // reference model of the AEAD command protocol
   int              m_phase = 0;          // 0 idle, 1 accepting data, 2 tag done
   bit              m_msg_seen, m_aad_part, m_msg_part, m_enc, m_err, m_tc;
   longint unsigned m_aad, m_msg;
   int              e_cc_init = 0, e_cc_next = 0, e_p_init = 0, e_p_fin = 0;
   int              exp_q[$];

   task automatic model_clear();
      m_aad = 0; m_msg = 0; m_msg_seen = 0; m_aad_part = 0; m_msg_part = 0;
      m_err = 0; m_tc = 0;
   endtask

   task automatic model_cmd(input bit i, input bit f, input bit m, input bit a, input int b);
      if (i) begin
         model_clear();
         m_phase = 1; m_enc = encdec;
         e_cc_init++; e_p_init++;
      end else if (f) begin
         if (m_phase == 1) begin
            exp_q.push_back(2 * 1000 + 16);
            e_p_fin++;
            m_phase = 2;
            m_tc = !m_enc && (cif.p_tag == tag_in);
         end else m_err = 1;
      end else if (m) begin
         if (m_phase == 1 && !m_msg_part && b >= 1 && b <= 64) begin
            e_cc_next++;
            for (int k = 0; k * 16 < b; k++)
               exp_q.push_back(1000 + k * 100 + ((b - 16 * k > 16) ? 16 : b - 16 * k));
            m_msg += longint'(b); m_msg_seen = 1; m_msg_part = (b < 64);
         end else m_err = 1;
      end else if (a) begin
         if (m_phase == 1 && !m_msg_seen && !m_aad_part && b >= 1 && b <= 16) begin
            exp_q.push_back(b);
            m_aad += longint'(b); m_aad_part = (b < 16);
         end else m_err = 1;
      end
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", ready, 1);
   endtask

   task automatic apply(input bit i, input bit f, input bit m, input bit a, input int b);
      model_cmd(i, f, m, a, b);
      @(negedge clk);
      init = i; finalize = f; msg_next = m; aad_next = a; blen = 7'(b);
      @(negedge clk);
      init = 0; finalize = 0; msg_next = 0; aad_next = 0;
      wait_ready();
   endtask

   task automatic check_all(input string tag);
      check({tag, ".aad_len"}, aad_len, m_aad);
      check({tag, ".msg_len"}, msg_len, m_msg);
      check({tag, ".cc_init_n"}, n_cc_init, e_cc_init);
      check({tag, ".cc_next_n"}, n_cc_next, e_cc_next);
      check({tag, ".p_init_n"}, n_p_init, e_p_init);
      check({tag, ".p_finish_n"}, n_p_fin, e_p_fin);
      check({tag, ".p_next_n"}, obs_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         check({tag, ".p_next_blk"}, obs_q[k], exp_q[k]);
      check({tag, ".tag_valid"}, tag_valid, (m_phase == 2));
      check({tag, ".tag_correct"}, tag_correct, (m_phase == 2) && m_tc);
`ifdef CHACHA_POLY_CTRL_ERR_EN
      check({tag, ".error"}, error, m_err);
`endif
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic run_rfc(input bit enc, input logic [127:0] tin, input bit exp_tc, input string tag);
      encdec = enc; tag_in = tin; cif.p_tag = RFC_TAG;
      apply(1, 0, 0, 0, 0);
      check({tag, ".tv_cleared"}, tag_valid, 0);
      apply(0, 0, 0, 1, 12);
      apply(0, 0, 1, 0, 64);
      apply(0, 0, 1, 0, 50);
      apply(0, 1, 0, 0, 0);
      check({tag, ".aad12"}, aad_len, 12);
      check({tag, ".msg114"}, msg_len, 114);
      check({tag, ".pnext10"}, obs_q.size(), 10);
      check({tag, ".tc_const"}, tag_correct, exp_tc);
      check_all(tag);
   endtask

   initial begin
      int n, r, b;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst.ready", ready, 1);
      check("rst.outs", {tag_valid, tag_correct, aad_len, msg_len, cif.cc_init, cif.cc_next,
                         cif.p_init, cif.p_next, cif.p_finish, cif.p_sel, cif.p_chunk, cif.p_blen}, 0);
      reset_n = 1'b1;

      // RFC 8439 vector, encrypt then decrypt (good tag, then tag with bit 0 flipped)
      run_rfc(1'b1, RFC_TAG, 1'b0, "rfc_enc");
      run_rfc(1'b0, RFC_TAG, 1'b1, "rfc_dec_ok");
      run_rfc(1'b0, RFC_TAG ^ 128'h1, 1'b0, "rfc_dec_bad");

      // empty AAD and message
      encdec = 1'b1;
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      check_all("empty");

      // finalize outranks msg_next presented in the same cycle
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 30);
      check_all("prio");

      // AAD after message data is rejected
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 64);
      apply(0, 0, 0, 1, 16);
      check("aad_after_msg.len", aad_len, 0);
      check_all("aad_after_msg");

      // 17-byte message splits 16 + 1, then further message blocks are rejected
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 17);
      check("msg17.len", msg_len, 17);
      check("msg17.chunks", obs_q.size(), 2);
      apply(0, 0, 1, 0, 64);
      apply(0, 0, 0, 1, 0);
      apply(0, 0, 1, 0, 65);
      check_all("msg17");

      // reset while the third ciphertext chunk is in flight
      apply(1, 0, 0, 0, 0);
      @(negedge clk);
      msg_next = 1; blen = 7'd64;
      @(negedge clk);
      msg_next = 0;
      n = 0;
      while (!(cif.p_next === 1'b1 && cif.p_chunk === 2'd2) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid.reach_chunk2", cif.p_chunk, 2);
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_mid.ready", ready, 1);
      check("rst_mid.outs", {tag_valid, tag_correct, aad_len, msg_len, cif.cc_init, cif.cc_next,
                             cif.p_init, cif.p_next, cif.p_finish, cif.p_sel, cif.p_chunk, cif.p_blen}, 0);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      model_clear();
      m_phase = 0;
      obs_q.delete(); exp_q.delete();
      n_cc_init = 0; n_cc_next = 0; n_p_init = 0; n_p_fin = 0;
      e_cc_init = 0; e_cc_next = 0; e_p_init = 0; e_p_fin = 0;
      apply(0, 0, 1, 0, 64);
      check_all("idle_msg");
      run_rfc(1'b1, RFC_TAG, 1'b0, "rfc_after_rst");

      // randomized command streams, including illegal lengths and DONE-state commands
      for (int it = 0; it < 24; it++) begin
         encdec = 1'($urandom_range(1, 0));
         cif.p_tag = {$urandom, $urandom, $urandom, $urandom};
         tag_in = ($urandom_range(1, 0) == 1) ? cif.p_tag : cif.p_tag ^ (128'h1 << $urandom_range(127, 0));
         apply(1, 0, 0, 0, 0);
         n = $urandom_range(6, 0);
         for (int j = 0; j < n; j++) begin
            r = $urandom_range(3, 0);
            b = (r == 0) ? $urandom_range(17, 0) : $urandom_range(65, 0);
            apply(0, 0, r != 0, r == 0 || r == 3, b);
         end
         apply(0, 1, 0, 0, 0);
         if (it % 3 == 0) apply(0, 0, 0, 1, 16);
         check_all("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
